// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the N-client AXI read arbiter.
// Included by the arbiter top and its request-selection sub-module.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int AXI_LEN_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request selector: rotating search from ptr (round-robin)
// or from index 0 (fixed priority). Produces a one-hot grant and its index.
module rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] base;
    logic [IW-1:0] cand;
    logic          found;

    assign base = (int'(mode) == ARB_FIXED) ? '0 : ptr;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(base) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter_nch.sv
// N-client AXI read arbiter: one burst at a time onto a single read port,
// data routed to the owner until rlast, burst length checked against arlen.
module axi_read_arbiter_nch
    import axi_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ARB_MODE    = 0,
    parameter int IW          = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_CLIENTS*AXI_LEN_W-1:0]  s_arlen,
    input  logic [NUM_CLIENTS-1:0]            s_arvalid,
    output logic [NUM_CLIENTS-1:0]            s_arready,
    output logic [DATA_WIDTH-1:0]             s_rdata,
    output logic [NUM_CLIENTS-1:0]            s_rvalid,
    output logic [NUM_CLIENTS-1:0]            s_rlast,
    input  logic [NUM_CLIENTS-1:0]            s_rready,
    output logic [ADDR_WIDTH-1:0]             m_araddr,
    output logic [AXI_LEN_W-1:0]              m_arlen,
    output logic                              m_arvalid,
    input  logic                              m_arready,
    input  logic [DATA_WIDTH-1:0]             m_rdata,
    input  logic                              m_rvalid,
    input  logic                              m_rlast,
    output logic                              m_rready,
    output logic [IW-1:0]                     grant_id,
    output logic                              busy,
    output logic                              len_err,
    output arb_state_t                        state_dbg
);

    // Handshakes: a beat/address transfers on a cycle where valid & ready are both high;
    // valid never depends on ready, and the arbiter only passes ready/valid through.
    arb_state_t             state, state_next;
    logic [IW-1:0]          ptr;
    logic [8:0]             beat_cnt;
    logic [NUM_CLIENTS-1:0] arb_grant;
    logic [IW-1:0]          arb_idx;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [AXI_LEN_W-1:0]   win_len;
    logic                   r_fire;

    rr_arbiter #(
        .N  (NUM_CLIENTS),
        .IW (IW)
    ) u_arb (
        .req   (s_arvalid),
        .ptr   (ptr),
        .mode  (ARB_MODE == ARB_FIXED),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (arb_grant[i]) begin
                win_addr = win_addr | s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_len  = win_len | s_arlen[i*AXI_LEN_W +: AXI_LEN_W];
            end
        end
    end

    assign r_fire = (state == DATA) && m_rvalid && s_rready[grant_id];

    always_comb begin
        state_next = state;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s_arready  = '0;
        s_rvalid   = '0;
        s_rlast    = '0;
        case (state)
            IDLE: begin
                if (|s_arvalid) state_next = ADDR;
            end
            ADDR: begin
                m_arvalid           = 1'b1;
                s_arready[grant_id] = m_arready;
                if (m_arready) state_next = DATA;
            end
            DATA: begin
                m_rready           = s_rready[grant_id];
                s_rvalid[grant_id] = m_rvalid;
                s_rlast[grant_id]  = m_rlast;
                if (r_fire && m_rlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            m_araddr <= '0;
            m_arlen  <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            state   <= state_next;
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|s_arvalid) begin
                        grant_id <= arb_idx;
                        m_araddr <= win_addr;
                        m_arlen  <= win_len;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        beat_cnt <= '0;
                        if (ARB_MODE == ARB_RR)
                            ptr <= (int'(grant_id) == NUM_CLIENTS - 1) ? '0 : grant_id + 1'b1;
                    end
                end
                DATA: begin
                    if (r_fire) begin
                        if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
                        // counter holds beats already taken, so a well-formed burst ends at arlen
                        if (m_rlast && beat_cnt != {1'b0, m_arlen}) len_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign s_rdata   = m_rdata;
    assign state_dbg = state;

endmodule

// File: tb/tb_axi_read_arbiter_nch.sv
// Directed + randomized bench for axi_read_arbiter_nch with a round-robin and a
// fixed-priority instance sharing stimulus; checks against a burst-level model.
module tb_axi_read_arbiter_nch;
    import axi_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*AW-1:0] s_araddr;
    logic [N*8-1:0]  s_arlen;
    logic [N-1:0]    s_arvalid, s_rready;
    logic            m_arready, m_rvalid, m_rlast;
    logic [DW-1:0]   m_rdata;

    logic [N-1:0]  rr_s_arready, rr_s_rvalid, rr_s_rlast, fp_s_arready, fp_s_rvalid, fp_s_rlast;
    logic [DW-1:0] rr_s_rdata, fp_s_rdata;
    logic [AW-1:0] rr_m_araddr, fp_m_araddr;
    logic [7:0]    rr_m_arlen, fp_m_arlen;
    logic          rr_m_arvalid, fp_m_arvalid, rr_m_rready, fp_m_rready;
    logic          rr_busy, fp_busy, rr_len_err, fp_len_err;
    logic [IW-1:0] rr_grant_id, fp_grant_id;
    arb_state_t    rr_state, fp_state;

    axi_read_arbiter_nch #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid),
        .s_arready(rr_s_arready), .s_rdata(rr_s_rdata), .s_rvalid(rr_s_rvalid), .s_rlast(rr_s_rlast),
        .s_rready(s_rready), .m_araddr(rr_m_araddr), .m_arlen(rr_m_arlen), .m_arvalid(rr_m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_rready(rr_m_rready), .grant_id(rr_grant_id), .busy(rr_busy), .len_err(rr_len_err),
        .state_dbg(rr_state)
    );

    axi_read_arbiter_nch #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid),
        .s_arready(fp_s_arready), .s_rdata(fp_s_rdata), .s_rvalid(fp_s_rvalid), .s_rlast(fp_s_rlast),
        .s_rready(s_rready), .m_araddr(fp_m_araddr), .m_arlen(fp_m_arlen), .m_arvalid(fp_m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_rready(fp_m_rready), .grant_id(fp_grant_id), .busy(fp_busy), .len_err(fp_len_err),
        .state_dbg(fp_state)
    );

    // Observed view: whichever instance the current section targets
    logic use_fp = 1'b0;
    logic [N-1:0]  o_s_arready, o_s_rvalid, o_s_rlast;
    logic [DW-1:0] o_s_rdata;
    logic [AW-1:0] o_m_araddr;
    logic [7:0]    o_m_arlen;
    logic          o_m_arvalid, o_m_rready, o_busy, o_len_err;
    logic [IW-1:0] o_grant_id;
    arb_state_t    o_state;

    assign o_s_arready = use_fp ? fp_s_arready : rr_s_arready;
    assign o_s_rvalid  = use_fp ? fp_s_rvalid  : rr_s_rvalid;
    assign o_s_rlast   = use_fp ? fp_s_rlast   : rr_s_rlast;
    assign o_s_rdata   = use_fp ? fp_s_rdata   : rr_s_rdata;
    assign o_m_araddr  = use_fp ? fp_m_araddr  : rr_m_araddr;
    assign o_m_arlen   = use_fp ? fp_m_arlen   : rr_m_arlen;
    assign o_m_arvalid = use_fp ? fp_m_arvalid : rr_m_arvalid;
    assign o_m_rready  = use_fp ? fp_m_rready  : rr_m_rready;
    assign o_busy      = use_fp ? fp_busy      : rr_busy;
    assign o_len_err   = use_fp ? fp_len_err   : rr_len_err;
    assign o_grant_id  = use_fp ? fp_grant_id  : rr_grant_id;
    assign o_state     = use_fp ? fp_state     : rr_state;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: request mask, per-client request contents, priority pointer
    logic [N-1:0] req;
    logic [31:0]  addr_tab[N];
    int           len_tab[N];
    int           ptr_m;
    bit           fixed_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            s_araddr[i*AW +: AW] = addr_tab[i];
            s_arlen[i*8 +: 8]    = 8'(len_tab[i]);
        end
        s_arvalid = req;
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p, input bit fixed);
        int start;
        int j;
        start = fixed ? 0 : p;
        for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (((m >> j) & 1) != 0) return j;
        end
        return 0;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_state"},    o_state, IDLE);
        check({tag, "_arvalid"},  o_m_arvalid, 0);
        check({tag, "_rready"},   o_m_rready, 0);
        check({tag, "_busy"},     o_busy, 0);
        check({tag, "_len_err"},  o_len_err, 0);
        check({tag, "_s_arready"}, o_s_arready, 0);
        check({tag, "_s_rvalid"}, o_s_rvalid, 0);
        check({tag, "_s_rlast"},  o_s_rlast, 0);
        check({tag, "_grant_id"}, o_grant_id, 0);
        check({tag, "_araddr"},   o_m_araddr, 0);
        check({tag, "_arlen"},    o_m_arlen, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        drive_req();
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rdata   = '0;
        s_rready  = '0;
        tick();
        tick();
        #1;
        check_reset("reset");
        rst   = 1'b0;
        ptr_m = 0;
    endtask

    // One complete burst to client c; requests must already be driven with the DUT idle.
    task automatic serve(input int c, input int beats, input int ar_wait, input int stall_beat);
        logic [N-1:0]  oh;
        logic [DW-1:0] d;
        int            len;
        oh  = N'(1 << c);
        len = len_tab[c];
        tick();
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        s_rready = '1;
        #1;
        check("ar_valid", o_m_arvalid, 1);
        check("grant_id", o_grant_id, c);
        check("ar_addr", o_m_araddr, addr_tab[c]);
        check("ar_len", o_m_arlen, len);
        check("busy_addr", o_busy, 1);
        check("len_err_quiet", o_len_err, 0);
        check("stray_rready", o_m_rready, 0);
        check("stray_rvalid", o_s_rvalid, 0);
        for (int w = 0; w < ar_wait; w++) begin
            m_arready = 1'b0;
            #1;
            check("bp_arready", o_s_arready, 0);
            check("bp_arvalid", o_m_arvalid, 1);
            check("bp_addr", o_m_araddr, addr_tab[c]);
            tick();
        end
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_arready = 1'b1;
        #1;
        check("ar_hs_arready", o_s_arready, oh);
        tick();
        m_arready = 1'b0;
        for (int b = 0; b < beats; b++) begin
            d        = DW'($urandom);
            m_rdata  = d;
            m_rvalid = 1'b1;
            m_rlast  = (b == beats - 1);
            if (b == stall_beat) begin
                for (int s = 0; s < 3; s++) begin
                    s_rready = N'($urandom) & ~oh;
                    #1;
                    check("stall_rready", o_m_rready, 0);
                    check("stall_rvalid", o_s_rvalid, oh);
                    tick();
                end
            end
            s_rready = N'($urandom) | oh;
            #1;
            check("beat_rready", o_m_rready, 1);
            check("beat_rvalid", o_s_rvalid, oh);
            check("beat_rlast", o_s_rlast, (b == beats - 1) ? oh : '0);
            check("beat_rdata", o_s_rdata, d);
            check("beat_arvalid", o_m_arvalid, 0);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        check("end_busy", o_busy, 0);
        check("end_len_err", o_len_err, (beats - 1) != len);
        if (!fixed_m) ptr_m = (c + 1) % N;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int beats;
        int stall;
        fixed_m = 1'b0;
        use_fp  = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_tab[i] = 32'h1000 * (i + 1);
            len_tab[i]  = 0;
        end
        apply_reset();

        // Single client: client 1, address 0x40, four beats
        addr_tab[1] = 32'h40;
        len_tab[1]  = 3;
        req = 3'b010;
        drive_req();
        serve(1, 4, 0, -1);
        req = '0;
        drive_req();

        // Round-robin fairness with all three requesting single-beat bursts
        apply_reset();
        for (int i = 0; i < N; i++) len_tab[i] = 0;
        req = 3'b111;
        drive_req();
        for (int k = 0; k < 6; k++) begin
            c = pick(req, ptr_m, fixed_m);
            serve(c, 1, 0, -1);
        end

        // Address backpressure then read-data stall
        req = 3'b100;
        len_tab[2] = 3;
        drive_req();
        serve(pick(req, ptr_m, fixed_m), 4, 5, 2);

        // Short burst against arlen 7, then a normal burst
        req = 3'b001;
        len_tab[0] = 7;
        drive_req();
        serve(pick(req, ptr_m, fixed_m), 5, 0, -1);
        req = 3'b010;
        len_tab[1] = 2;
        drive_req();
        serve(pick(req, ptr_m, fixed_m), 3, 1, -1);

        // Randomized bursts; pending requests keep their address and length
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) begin
                if (((req >> i) & 1) == 0) begin
                    addr_tab[i] = $urandom;
                    len_tab[i]  = $urandom_range(0, 7);
                end
            end
            req = req | N'($urandom_range(0, 7));
            if (req == '0) req = N'(1 << $urandom_range(0, N - 1));
            drive_req();
            c     = pick(req, ptr_m, fixed_m);
            beats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : len_tab[c] + 1;
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(0, beats - 1) : -1;
            serve(c, beats, $urandom_range(0, 2), stall);
            req = req & ~N'(1 << c);
        end
        req = '0;
        drive_req();

        // Reset during beat 2 of an 8-beat burst with the pointer away from 0
        apply_reset();
        len_tab[0] = 0;
        req = 3'b001;
        drive_req();
        serve(0, 1, 0, -1);
        len_tab[1] = 7;
        req = 3'b010;
        drive_req();
        tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 32'hA5A5_0001;
        s_rready  = '1;
        tick();
        m_rdata = 32'hA5A5_0002;
        rst     = 1'b1;
        tick();
        #1;
        check_reset("mid_rst");
        rst = 1'b0;
        req = '0;
        drive_req();
        ptr_m = 0;
        tick();
        #1;
        check("idle_stray_rready", o_m_rready, 0);
        check("idle_stray_rvalid", o_s_rvalid, 0);
        check("idle_busy", o_busy, 0);
        m_rvalid = 1'b0;
        len_tab[0] = 1;
        len_tab[2] = 1;
        req = 3'b101;
        drive_req();
        serve(pick(req, ptr_m, fixed_m), 2, 0, -1);
        req = 3'b100;
        drive_req();
        serve(pick(req, ptr_m, fixed_m), 2, 0, -1);
        req = '0;
        drive_req();

        // Fixed priority: client 0 wins until it stops requesting
        use_fp  = 1'b1;
        fixed_m = 1'b1;
        apply_reset();
        len_tab[0] = 0;
        len_tab[2] = 0;
        req = 3'b101;
        drive_req();
        for (int k = 0; k < 3; k++) serve(pick(req, ptr_m, fixed_m), 1, 0, -1);
        req = 3'b100;
        drive_req();
        serve(pick(req, ptr_m, fixed_m), 1, 0, -1);
        req = '0;
        drive_req();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
